ula_op_sequencer: RTL and testbench
===================================

Name: ula_op_sequencer

Overview:
Sequencing controller for the 4-bit ULA. Accepts one operation at a time via a start/done handshake, runs single-cycle ops (add, sub, logic) and multi-cycle ops (shift-add multiply, restoring divide), and registers the result and flags. Applies the arithmetic-only rule for Negative: flags are qualified by op class. Sits between the top-level operand/op registers and the display/flag outputs.

Parameters:
WIDTH, 4, operand/result width; iteration count for mul/div equals WIDTH.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only when ready=1
op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DIV, 111 NOT A
a  in  WIDTH  operand A, captured on accept
b  in  WIDTH  operand B, captured on accept
ready  out  1  high in IDLE only
done  out  1  one-cycle pulse when result/flags update
result  out  WIDTH  registered result, held until next done
negative  out  1  result MSB, arithmetic ops only (000,001,101,110); else 0
zero  out  1  result == 0, all ops
carry  out  1  ADD: carry-out; SUB: 1 when a >= b unsigned (no borrow); else 0
overflow  out  1  ADD/SUB: signed overflow; MUL: high nibble of product nonzero; else 0
div_err  out  1  DIV with b == 0; else 0

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, done=0, result=0, all flags=0, iteration counter=0, operand regs=0.
- States: IDLE, ITER, DONE.
- IDLE: ready=1. start=1 accepts op/a/b at that edge.
  - Single-cycle op (000,001,010,011,100,111): result and flags computed and registered at accept edge; next state DONE. Latency 1 cycle (done high the cycle after accept).
  - MUL/DIV: load operands, counter=WIDTH-1; next state ITER.
  - DIV with b==0: no ITER; result=all ones, div_err=1, other flags per rules; next state DONE (latency 1).
- ITER: one shift-add (MUL, unsigned, 2*WIDTH-bit product) or one restoring step (DIV, unsigned quotient) per cycle; counter decrements; at counter==0 register result/flags and go to DONE. MUL/DIV latency WIDTH+1 cycles (5 for WIDTH=4). MUL result = low WIDTH bits. DIV result = quotient; remainder discarded.
- DONE: done=1 for exactly one cycle, ready=0; unconditional return to IDLE.
- start while ready=0: ignored, not queued; op/a/b changes during ITER have no effect.
- result and flags change only on the edge entering DONE; stable at all other times.
- Reset asserted mid-ITER: operation aborted, no done pulse, outputs at reset values.
- Back-to-back: start held high yields one accept per IDLE visit (minimum 2 cycles per single-cycle op).

Optional Feature:
ULA_DIV_EN: defined -> DIV implemented as above. Undefined -> divider logic omitted; op 110 completes in 1 cycle with result=0, div_err=1, negative=0, zero=1, carry=0, overflow=0.

Decomposition:
- Package ula_pkg: op-code constants (OP_ADD..OP_NOT), state enum (IDLE, ITER, DONE), WIDTH default constant, function is_arith(op) for the 000/001/101/110 class.
- One sub-module: ula_flag_gen (combinational) computing negative/zero/carry/overflow from result, op, carry-out and high-product bits; instantiated once at the DONE-entry register stage.

Test Plan:
- ADD a=0111 b=0001 -> done 1 cycle after accept; result=1000, negative=1, overflow=1, carry=0, zero=0.
- SUB a=0011 b=0101 -> result=1110, negative=1, carry=0, overflow=0; SUB a=0101 b=0101 -> result=0000, zero=1, carry=1.
- MUL a=0011 b=0101 -> done exactly 5 cycles after accept, result=1111, negative=1, overflow=0; MUL 0100*0100 -> result=0000, zero=1, overflow=1; start pulses during ITER ignored.
- DIV a=1101 b=0011 -> result=0100, negative=0, latency 5; DIV b=0000 -> result=1111, div_err=1, latency 1 (repeat with ULA_DIV_EN undefined: result=0000, div_err=1).
- AND a=1100 b=1010 -> result=1000, negative=0 (logic op), zero=0; NOT a=0000 -> result=1111, negative=0.
- Reset asserted on 2nd ITER cycle of MUL -> no done pulse, result/flags=0, ready=1 immediately; next ADD 0001+0001 -> result=0010.

Source files
------------

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - op codes, FSM states and op-class helper for the ULA sequencer
package ula_pkg;

  localparam int ULA_WIDTH = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } ula_state_t;

  // Arithmetic class: the only ops allowed to report a negative result.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ula_flag_gen.sv
// rtl/ula_flag_gen.sv - combinational negative/zero/carry/overflow qualified by op class
module ula_flag_gen
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] result,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             carry_out,
  input  logic             hi_nonzero,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  always_comb begin
    negative = is_arith(op) & result[WIDTH-1];
    zero     = (result == '0);
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        carry    = carry_out;
        overflow = (a_msb == b_msb) && (result[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        // carry_out of a + ~b + 1 is set exactly when no borrow occurs
        carry    = carry_out;
        overflow = (a_msb != b_msb) && (result[WIDTH-1] != a_msb);
      end
      OP_MUL:  overflow = hi_nonzero;
      default: ;
    endcase
  end

endmodule

// File: rtl/ula_op_sequencer.sv
// rtl/ula_op_sequencer.sv - start/done ULA sequencer; ULA_DIV_EN enables the restoring divider
module ula_op_sequencer
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ula_state_t         state, state_nxt;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               accept, commit, iter_op;

  always_comb begin
    iter_op = (op == OP_MUL);
`ifdef ULA_DIV_EN
    if ((op == OP_DIV) && (b != '0)) iter_op = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (iter_op) begin
            state_nxt = ITER;
          end else begin
            state_nxt = DONE;
            commit    = 1'b1;
          end
        end
      end
      ITER: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  // Single-cycle ops are evaluated straight from the live operands at accept.
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cout, sc_derr;

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  always_comb begin
    sc_res  = '0;
    sc_cout = 1'b0;
    sc_derr = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res  = add_full[WIDTH-1:0];
        sc_cout = add_full[WIDTH];
      end
      OP_SUB: begin
        sc_res  = sub_full[WIDTH-1:0];
        sc_cout = sub_full[WIDTH];
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_NOT: sc_res = ~a;
      OP_DIV: begin
        sc_derr = 1'b1;
`ifdef ULA_DIV_EN
        sc_res  = '1;
`endif
      end
      default: ;
    endcase
  end

  // MSB-first shift-add: one multiplier bit per ITER cycle, indexed by cnt.
  logic [2*WIDTH-1:0] prod_nxt;
  assign prod_nxt = (acc << 1) + (b_r[cnt] ? {{WIDTH{1'b0}}, a_r} : '0);

`ifdef ULA_DIV_EN
  logic [WIDTH-1:0] quo, quo_nxt, rem_nxt;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             q_bit;

  assign rem_sh  = {acc[WIDTH-1:0], a_r[cnt]};
  assign rem_sub = rem_sh - {1'b0, b_r};
  assign q_bit   = (rem_sh >= {1'b0, b_r});
  assign rem_nxt = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], q_bit};
`endif

  logic [WIDTH-1:0] it_res;
  logic             it_hi;

  always_comb begin
    it_res = prod_nxt[WIDTH-1:0];
`ifdef ULA_DIV_EN
    if (op_r == OP_DIV) it_res = quo_nxt;
`endif
  end

  assign it_hi = |prod_nxt[2*WIDTH-1:WIDTH];

  // One flag generator serves both commit points; its inputs follow the state.
  logic [2:0]       fg_op;
  logic [WIDTH-1:0] fg_res;
  logic             fg_amsb, fg_bmsb, fg_cout, fg_hi, fg_derr;
  logic             fg_neg, fg_zero, fg_carry, fg_ovf;

  always_comb begin
    if (state == IDLE) begin
      fg_op   = op;
      fg_res  = sc_res;
      fg_amsb = a[WIDTH-1];
      fg_bmsb = b[WIDTH-1];
      fg_cout = sc_cout;
      fg_hi   = 1'b0;
      fg_derr = sc_derr;
    end else begin
      fg_op   = op_r;
      fg_res  = it_res;
      fg_amsb = a_r[WIDTH-1];
      fg_bmsb = b_r[WIDTH-1];
      fg_cout = 1'b0;
      fg_hi   = it_hi;
      fg_derr = 1'b0;
    end
  end

  ula_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .op         (fg_op),
    .result     (fg_res),
    .a_msb      (fg_amsb),
    .b_msb      (fg_bmsb),
    .carry_out  (fg_cout),
    .hi_nonzero (fg_hi),
    .negative   (fg_neg),
    .zero       (fg_zero),
    .carry      (fg_carry),
    .overflow   (fg_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      cnt      <= '0;
`ifdef ULA_DIV_EN
      quo      <= '0;
`endif
      result   <= '0;
      negative <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      if (accept) begin
        op_r <= op;
        a_r  <= a;
        b_r  <= b;
        acc  <= '0;
        cnt  <= CW'(WIDTH-1);
`ifdef ULA_DIV_EN
        quo  <= '0;
`endif
      end else if (state == ITER) begin
        if (cnt != '0) cnt <= cnt - CW'(1);
        acc <= prod_nxt;
`ifdef ULA_DIV_EN
        if (op_r == OP_DIV) begin
          acc <= {{WIDTH{1'b0}}, rem_nxt};
          quo <= quo_nxt;
        end
`endif
      end
      if (commit) begin
        result   <= fg_res;
        negative <= fg_neg;
        zero     <= fg_zero;
        carry    <= fg_carry;
        overflow <= fg_ovf;
        div_err  <= fg_derr;
      end
    end
  end

endmodule

// File: tb/tb_ula_op_sequencer.sv
// tb/tb_ula_op_sequencer.sv - randomized scoreboard bench for ula_op_sequencer
module tb_ula_op_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         ready, done;
  logic [W-1:0] result;
  logic         negative, zero, carry, overflow, div_err;

  ula_op_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .negative (negative),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] res;
    logic [4:0] flags;   // {negative, zero, carry, overflow, div_err}
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    int   ux, uy, sx, sy, r;
    logic n, z, c, v, er;
    ux = int'(x); uy = int'(y);
    sx = (ux >= 8) ? ux - 16 : ux;
    sy = (uy >= 8) ? uy - 16 : uy;
    r = 0; c = 1'b0; v = 1'b0; er = 1'b0;
    e.lat = 1;
    case (o)
      3'd0: begin r = (ux + uy) % 16; c = (ux + uy > 15); v = (sx + sy > 7) || (sx + sy < -8); end
      3'd1: begin r = (ux - uy + 16) % 16; c = (ux >= uy); v = (sx - sy > 7) || (sx - sy < -8); end
      3'd2: r = ux & uy;
      3'd3: r = ux | uy;
      3'd4: r = ux ^ uy;
      3'd5: begin r = (ux * uy) % 16; v = (ux * uy > 15); e.lat = 5; end
      3'd6: begin
        er = 1'b1;
`ifdef ULA_DIV_EN
        if (uy == 0) r = 15;
        else begin r = ux / uy; er = 1'b0; e.lat = 5; end
`else
        r = 0;
`endif
      end
      default: r = 15 - ux;
    endcase
    n = (o == 3'd0 || o == 3'd1 || o == 3'd5 || o == 3'd6) && (r >= 8);
    z = (r == 0);
    e.res   = r[3:0];
    e.flags = {n, z, c, v, er};
    e.acc   = 0;
    return e;
  endfunction

  // Waits for ready (driving ignored junk meanwhile), then issues one op.
  task automatic issue(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    int   guard = 0;
    while (ready !== 1'b1 && guard < 50) begin
      start = ($urandom_range(0, 2) != 0);
      op    = 3'($urandom);
      a     = 4'($urandom);
      b     = 4'($urandom);
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("ready_timeout", 32'(ready), 32'd1);
      return;
    end
    start = 1'b1; op = o; a = x; b = y;
    e     = model(o, x, y);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compares each done pulse against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_done: got done=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("flags", 32'({negative, zero, carry, overflow, div_err}), 32'(e.flags));
          check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  logic [2:0] d_op [9] = '{3'd0, 3'd1, 3'd1, 3'd5, 3'd5, 3'd6, 3'd6, 3'd2, 3'd7};
  logic [3:0] d_a  [9] = '{4'd7, 4'd3, 4'd5, 4'd3, 4'd4, 4'd13, 4'd5, 4'd12, 4'd0};
  logic [3:0] d_b  [9] = '{4'd1, 4'd5, 4'd5, 4'd5, 4'd4, 4'd3, 4'd0, 4'd10, 4'd0};

  initial begin
    int guard;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags", 32'({negative, zero, carry, overflow, div_err}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) issue(d_op[i], d_a[i], d_b[i]);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        start = 1'b0;
        @(negedge clk);
      end
      issue(3'($urandom), 4'($urandom), 4'($urandom));
    end

    // Abort a MUL on its second ITER cycle.
    issue(3'd5, 4'd3, 4'd5);
    start = 1'b0;
    @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", 32'({negative, zero, carry, overflow, div_err}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(3'd0, 4'd1, 4'd1);
    start = 1'b0;

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d outstanding ops, expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
